// File: rtl/blink_pattern_sequencer.sv
// Selects one of a small table of 32-bit blink patterns for lookup_blinker_32.
// Advances on a debounced button press or an auto timer, committing only at frame wrap.
module blink_pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 320000,
  parameter int NUM_PATTERNS    = 8,
  parameter int AUTO_FRAMES     = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BTN,
  input  logic        AUTO_EN,
  input  logic [4:0]  frame_index,
  output logic [31:0] blink_pattern,
  output logic [2:0]  pattern_sel,
  output logic        pending,
  output logic        dbg_state,
  output logic [2:0]  dbg_target
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FCNT_W = $clog2(AUTO_FRAMES + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  function automatic logic [31:0] table_lookup(input logic [2:0] idx);
    logic [31:0] pat;
    case (idx)
      3'd0:    pat = 32'b01010101010101001111111011111111;
      3'd1:    pat = 32'hFFFF0000;
      3'd2:    pat = 32'hAAAAAAAA;
      3'd3:    pat = 32'hF0F0F0F0;
      3'd4:    pat = 32'h80000000;
      3'd5:    pat = 32'hFFFFFFFF;
      3'd6:    pat = 32'h0000000F;
      default: pat = 32'hCCCCCCCC;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    logic [2:0] nxt;
    if (idx >= 3'(NUM_PATTERNS - 1)) nxt = 3'd0;
    else                             nxt = idx + 3'd1;
    return nxt;
  endfunction

  logic              sync1_q, btn_s_q;
  logic              stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        prev_index_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  state_t            state_q, state_d;
  logic [2:0]        target_q, target_d;
  logic [2:0]        sel_q, sel_d;
  logic [31:0]       pattern_q, pattern_d;
  logic              pending_q, pending_d;

  logic press, wrap, auto_req, req;

  // Debounce: press fires on the cycle the stable level is about to rise.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press    = 1'b0;
    if (btn_s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = btn_s_q;
      cnt_d    = '0;
      press    = btn_s_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign wrap = (prev_index_q == 5'd31) && (frame_index == 5'd0);

  always_comb begin
    fcnt_d   = fcnt_q;
    auto_req = 1'b0;
    if (!AUTO_EN || state_q == PENDING) begin
      fcnt_d = '0;
    end else if (wrap) begin
      if (fcnt_q == FCNT_W'(AUTO_FRAMES - 1)) begin
        auto_req = 1'b1;
        fcnt_d   = '0;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  assign req = press | auto_req;

  // A wrap commits only what was already pending; a request arriving with it queues the next step.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sel_d     = sel_q;
    pattern_d = pattern_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = PENDING;
          target_d = next_idx(sel_q);
        end
      end
      PENDING: begin
        if (wrap) begin
          sel_d     = target_q;
          pattern_d = table_lookup(target_q);
          if (req) target_d = next_idx(target_q);
          else     state_d  = IDLE;
        end else if (req) begin
          target_d = next_idx(target_q);
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (state_d == PENDING);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      stable_q     <= 1'b0;
      cnt_q        <= '0;
      prev_index_q <= 5'd0;
      fcnt_q       <= '0;
      state_q      <= IDLE;
      target_q     <= 3'd0;
      sel_q        <= 3'd0;
      pattern_q    <= table_lookup(3'd0);
      pending_q    <= 1'b0;
    end else begin
      sync1_q      <= BTN;
      btn_s_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      prev_index_q <= frame_index;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      target_q     <= target_d;
      sel_q        <= sel_d;
      pattern_q    <= pattern_d;
      pending_q    <= pending_d;
    end
  end

  assign blink_pattern = pattern_q;
  assign pattern_sel   = sel_q;
  assign pending       = pending_q;
  assign dbg_state     = state_q;
  assign dbg_target    = target_q;

endmodule

// File: tb/tb_blink_pattern_sequencer.sv
// Self-checking bench for blink_pattern_sequencer: a behavioural model predicts commits,
// which are queued and matched against every observed change of pattern_sel/blink_pattern.
module tb_blink_pattern_sequencer;

  localparam int DEB = 16;
  localparam int NP  = 8;
  localparam int AF  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b0;
  logic        auto_en = 1'b0;
  logic [4:0]  frame_index = 5'd0;
  logic [31:0] blink_pattern;
  logic [2:0]  pattern_sel;
  logic        pending;
  logic        dbg_state;
  logic [2:0]  dbg_target;

  int checks = 0;
  int errors = 0;

  logic [31:0] tbl [8] = '{32'b01010101010101001111111011111111, 32'hFFFF0000,
                           32'hAAAAAAAA, 32'hF0F0F0F0, 32'h80000000,
                           32'hFFFFFFFF, 32'h0000000F, 32'hCCCCCCCC};

  logic [34:0] exp_q[$];
  int m_sel = 0, m_target = 0, m_fcnt = 0;
  bit m_pending = 1'b0;

  blink_pattern_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .NUM_PATTERNS(NP), .AUTO_FRAMES(AF)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .BTN(btn), .AUTO_EN(auto_en),
    .frame_index(frame_index), .blink_pattern(blink_pattern),
    .pattern_sel(pattern_sel), .pending(pending),
    .dbg_state(dbg_state), .dbg_target(dbg_target)
  );

  always #5 clk = ~clk;

  // Scoreboard: every visible change of the committed outputs must match the next predicted commit.
  logic [2:0]  last_sel = 3'd0;
  logic [31:0] last_pat = 32'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sel = pattern_sel;
      last_pat = blink_pattern;
    end else if (pattern_sel !== last_sel || blink_pattern !== last_pat) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected got sel=%0d pat=%h expected no change", pattern_sel, blink_pattern);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({pattern_sel, blink_pattern} !== e) begin
          errors++;
          $display("FAIL commit_value got sel=%0d pat=%h expected sel=%0d pat=%h",
                   pattern_sel, blink_pattern, e[34:32], e[31:0]);
        end
      end
      last_sel = pattern_sel;
      last_pat = blink_pattern;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit press, input bit wrap);
    bit auto_req = 1'b0;
    bit req;
    if (!auto_en || m_pending) m_fcnt = 0;
    else if (wrap) begin
      if (m_fcnt + 1 == AF) begin auto_req = 1'b1; m_fcnt = 0; end
      else m_fcnt = m_fcnt + 1;
    end
    req = press | auto_req;
    if (m_pending && wrap) begin
      m_sel = m_target;
      exp_q.push_back({3'(m_sel), tbl[m_sel]});
      if (req) m_target = (m_target + 1) % NP;
      else     m_pending = 1'b0;
    end else if (req) begin
      if (m_pending) m_target = (m_target + 1) % NP;
      else begin m_target = (m_sel + 1) % NP; m_pending = 1'b1; end
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_target = 0; m_fcnt = 0; m_pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic press_btn(input int hold);
    btn = 1'b1;
    repeat (hold) tick();
    btn = 1'b0;
    repeat (DEB + 6) tick();
  endtask

  task automatic do_wrap(input string name);
    frame_index = 5'd31;
    tick();
    frame_index = 5'd0;
    #1;
    checks++;
    if (blink_pattern !== tbl[m_sel]) begin
      errors++;
      $display("FAIL %s_early got %h expected %h", name, blink_pattern, tbl[m_sel]);
    end
    tick();
    model_step(1'b0, 1'b1);
    checks++;
    if (pattern_sel !== 3'(m_sel) || pending !== m_pending) begin
      errors++;
      $display("FAIL %s got sel=%0d pend=%0b expected sel=%0d pend=%0b",
               name, pattern_sel, pending, m_sel, m_pending);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++;
    if (blink_pattern !== 32'b01010101010101001111111011111111 || pattern_sel !== 3'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got pat=%h sel=%0d pend=%0b expected pat=%h sel=0 pend=0",
               blink_pattern, pattern_sel, pending, tbl[0]);
    end
    for (int i = 0; i < 20; i++) begin
      frame_index = 5'(i);
      tick();
    end
    checks++;
    if (blink_pattern !== tbl[0] || pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_steady got pat=%h pend=%0b expected pat=%h pend=0", blink_pattern, pending, tbl[0]);
    end
  endtask

  task automatic test_press_commit();
    frame_index = 5'd10;
    press_btn(DEB + 3);
    model_step(1'b1, 1'b0);
    checks++;
    if (pending !== 1'b1 || blink_pattern !== tbl[0] || pattern_sel !== 3'd0) begin
      errors++;
      $display("FAIL press_pending got pend=%0b pat=%h sel=%0d expected pend=1 pat=%h sel=0",
               pending, blink_pattern, pattern_sel, tbl[0]);
    end
    do_wrap("press_commit");
    checks++;
    if (blink_pattern !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL press_commit_pat got %h expected ffff0000", blink_pattern);
    end
  endtask

  task automatic test_glitch();
    btn = 1'b1;
    repeat (DEB / 2) tick();
    btn = 1'b0;
    repeat (DEB + 6) tick();
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored got pend=%0b expected 0", pending);
    end
  endtask

  task automatic test_accumulate();
    for (int i = 0; i < 3; i++) begin
      press_btn(DEB + 3);
      model_step(1'b1, 1'b0);
    end
    checks++;
    if (dbg_target !== 3'(m_target) || pending !== 1'b1) begin
      errors++;
      $display("FAIL accum_target got tgt=%0d pend=%0b expected tgt=%0d pend=1", dbg_target, pending, m_target);
    end
    frame_index = 5'd31;
    tick();
    frame_index = 5'd5;
    tick();
    checks++;
    if (pattern_sel !== 3'(m_sel) || pending !== 1'b1) begin
      errors++;
      $display("FAIL nonwrap_jump got sel=%0d pend=%0b expected sel=%0d pend=1", pattern_sel, pending, m_sel);
    end
    do_wrap("accum_commit");
    checks++;
    if (blink_pattern !== 32'h80000000) begin
      errors++;
      $display("FAIL accum_commit_pat got %h expected 80000000", blink_pattern);
    end
  endtask

  task automatic test_press_on_wrap();
    press_btn(DEB + 3);
    model_step(1'b1, 1'b0);
    frame_index = 5'd31;
    tick();
    btn = 1'b1;
    repeat (DEB + 1) tick();
    frame_index = 5'd0;
    tick();
    model_step(1'b1, 1'b1);
    checks++;
    if (pattern_sel !== 3'(m_sel) || pending !== 1'b1 || dbg_target !== 3'(m_target)) begin
      errors++;
      $display("FAIL press_on_wrap got sel=%0d pend=%0b tgt=%0d expected sel=%0d pend=1 tgt=%0d",
               pattern_sel, pending, dbg_target, m_sel, m_target);
    end
    btn = 1'b0;
    repeat (DEB + 6) tick();
    do_wrap("after_press_on_wrap");
    press_btn(DEB + 3);
    model_step(1'b1, 1'b0);
    do_wrap("to_last_entry");
  endtask

  task automatic test_auto_wrap();
    auto_en = 1'b1;
    do_wrap("auto_wrap1");
    do_wrap("auto_wrap2");
    checks++;
    if (pending !== 1'b1 || pattern_sel !== 3'd7) begin
      errors++;
      $display("FAIL auto_req got pend=%0b sel=%0d expected pend=1 sel=7", pending, pattern_sel);
    end
    do_wrap("auto_commit");
    checks++;
    if (pattern_sel !== 3'd0 || blink_pattern !== tbl[0]) begin
      errors++;
      $display("FAIL auto_wrap_around got sel=%0d pat=%h expected sel=0 pat=%h", pattern_sel, blink_pattern, tbl[0]);
    end
    auto_en = 1'b0;
    m_fcnt = 0;
    tick();
  endtask

  task automatic test_reset_pending();
    press_btn(DEB + 3);
    model_step(1'b1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pending !== 1'b0 || pattern_sel !== 3'd0 || blink_pattern !== tbl[0]) begin
      errors++;
      $display("FAIL reset_mid_pending got pend=%0b sel=%0d pat=%h expected pend=0 sel=0 pat=%h",
               pending, pattern_sel, blink_pattern, tbl[0]);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    do_wrap("no_commit_after_reset");
  endtask

  initial begin
    test_reset();
    test_press_commit();
    test_glitch();
    test_accumulate();
    test_press_on_wrap();
    test_auto_wrap();
    test_reset_pending();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
